// File: rtl/popcount_unary_encoder.sv
// Emits an N-bit vector with exactly in_count bits set, positions LFSR-shuffled.
// Scrambling is built only with POPCOUNT_ENC_SCRAMBLE_EN; otherwise plain thermometer.
module popcount_unary_encoder #(
  parameter int          N             = 8,
  parameter int          SHUFFLE_STEPS = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [$clog2(N):0]   in_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_vec,
  output logic [$clog2(N):0]   out_count,
  output logic                 out_sat
);

  localparam int LW = $clog2(N);
  localparam int CW = LW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd2;
`ifdef POPCOUNT_ENC_SCRAMBLE_EN
  localparam logic [1:0] S_SHUFFLE = 2'd1;
  localparam int         SW        = $clog2(SHUFFLE_STEPS + 1);
`endif

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [N-1:0]  vec_q;
  logic [CW-1:0] count_q;
  logic          sat_q;

  logic          accept;
  logic          release_hs;
  logic          sat_c;
  logic [CW-1:0] cnt_c;
  logic [N-1:0]  therm;

  assign accept     = in_valid & in_ready_q;
  assign release_hs = out_valid_q & out_ready;

  // Clamp first so the thermometer never needs more than N ones.
  assign sat_c = in_count > CW'(N);
  assign cnt_c = sat_c ? CW'(N) : in_count;

  always_comb begin
    therm = '0;
    for (int k = 0; k < N; k++) begin
      therm[k] = CW'(k) < cnt_c;
    end
  end

`ifdef POPCOUNT_ENC_SCRAMBLE_EN
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_nx;
  logic [SW-1:0] step_q;
  logic          last_step;
  logic [LW-1:0] idx_i;
  logic [LW-1:0] idx_j;
  logic [N-1:0]  vec_sw;

  assign lfsr_nx = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign last_step = step_q == SW'(SHUFFLE_STEPS - 1);
  assign idx_i     = LW'(int'(step_q) % N);
  assign idx_j     = lfsr_q[LW-1:0];

  // A swap only moves bits, so the popcount is preserved.
  always_comb begin
    vec_sw        = vec_q;
    vec_sw[idx_i] = vec_q[idx_j];
    vec_sw[idx_j] = vec_q[idx_i];
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE):    if (accept) state_d = S_SHUFFLE;
      (state_q == S_SHUFFLE): if (last_step) state_d = S_HOLD;
      (state_q == S_HOLD):    if (release_hs) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      step_q <= '0;
    end else if (state_q == S_IDLE && accept) begin
      step_q <= '0;
    end else if (state_q == S_SHUFFLE) begin
      lfsr_q <= lfsr_nx;
      step_q <= step_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (state_q == S_IDLE && accept) begin
      vec_q   <= therm;
      count_q <= cnt_c;
      sat_q   <= sat_c;
    end else if (state_q == S_SHUFFLE) begin
      vec_q   <= vec_sw;
    end
  end
`else
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE): if (accept) state_d = S_HOLD;
      (state_q == S_HOLD): if (release_hs) state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (state_q == S_IDLE && accept) begin
      vec_q   <= therm;
      count_q <= cnt_c;
      sat_q   <= sat_c;
    end
  end
`endif

  // Handshake flags are registered from the next state: no out_ready->in_ready path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= state_d == S_IDLE;
      out_valid_q <= state_d == S_HOLD;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_vec   = vec_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_popcount_unary_encoder.sv
// Randomised self-checking bench for popcount_unary_encoder.
// Follows POPCOUNT_ENC_SCRAMBLE_EN to pick the scrambled or thermometer model.
module tb_popcount_unary_encoder;

  localparam int          N     = 8;
  localparam int          STEPS = 8;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          CW    = $clog2(N) + 1;
`ifdef POPCOUNT_ENC_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif
  localparam int LAT = SCR ? STEPS + 1 : 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_count = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_vec;
  logic [CW-1:0] out_count;
  logic          out_sat;

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned m_lfsr = SEED;

  popcount_unary_encoder #(
    .N(N), .SHUFFLE_STEPS(STEPS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_count(out_count), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lfsr_step(input int unsigned l);
    int unsigned fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 32'hFFFF;
  endfunction

  // Reference: clamp, lay down c ones, then apply the swap schedule.
  task automatic model(input int cnt, output logic [N-1:0] v,
                       output int c, output bit s);
    bit b[N];
    bit t;
    int i;
    int j;
    s = cnt > N;
    c = s ? N : cnt;
    for (int k = 0; k < N; k++) b[k] = k < c;
    if (SCR) begin
      for (int st = 0; st < STEPS; st++) begin
        i = st % N;
        j = int'(m_lfsr % N);
        t = b[i]; b[i] = b[j]; b[j] = t;
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
    for (int k = 0; k < N; k++) v[k] = b[k];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    m_lfsr = SEED;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", in_ready, 1);
  endtask

  task automatic xact(input int cnt, input int hold, input bit spur,
                      output logic [N-1:0] got);
    logic [N-1:0] ev;
    int ec;
    bit es;
    int w;
    wait_ready();
    in_valid = 1'b1;
    in_count = CW'(cnt);
    model(cnt, ev, ec, es);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("latency", w, LAT - 1);
    chk("out_valid", out_valid, 1);
    chk("out_vec", out_vec, ev);
    chk("out_count", out_count, ec);
    chk("out_sat", out_sat, es);
    chk("popcount", $countones(out_vec), out_count);
    chk("busy_ready", in_ready, 0);
    got = out_vec;
    for (int h = 0; h < hold; h++) begin
      in_valid = spur;
      in_count = CW'($urandom_range(0, 15));
      @(negedge clk);
      chk("hold_vec", out_vec, ev);
      chk("hold_count", out_count, ec);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    logic [N-1:0] got;
    logic [N-1:0] first5;
    int c;

    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_vec", out_vec, 0);
    chk("rst_count", out_count, 0);
    chk("rst_sat", out_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_up", in_ready, 1);

    xact(3, 0, 1'b0, got);

    for (int k = 0; k <= N; k++) begin
      xact(k, 0, 1'b0, got);
      if (k == 0) chk("sweep_zero", got, 0);
      if (k == N) chk("sweep_full", got, 8'hFF);
    end

    xact(12, 0, 1'b0, got);
    chk("sat_vec", got, 8'hFF);

    xact(6, 20, 1'b1, got);
    @(negedge clk);
    chk("after_hold_valid", out_valid, 0);

    for (int r = 0; r < 25; r++) begin
      c = int'($urandom_range(0, 15));
      xact(c, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
    end

`ifndef POPCOUNT_ENC_SCRAMBLE_EN
    xact(5, 0, 1'b0, got);
    chk("therm_5", got, 8'h1F);
`endif

    apply_reset();
    xact(5, 0, 1'b0, first5);

    apply_reset();
    wait_ready();
    in_valid = 1'b1;
    in_count = CW'(5);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_vec", out_vec, 0);
    chk("abort_count", out_count, 0);
    chk("abort_ready", in_ready, 0);
    m_lfsr = SEED;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(5, 0, 1'b0, got);
    chk("seed_determinism", got, first5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
